// File: rtl/apo_input_arbiter_9_nodes.sv
// Input-side scheduler for apo_router_9_nodes: per-port FIFOs, one packet issued per cycle.
// Optional `ARB_LOCAL_PRIO_EN gives transit ports 1-4 strict priority over the local port 0.
module apo_input_arbiter_9_nodes #(
    parameter int unsigned PKT_W      = 9,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [PKT_W-1:0] in_free,
    input  logic [PKT_W-1:0] in_r1R,
    input  logic [PKT_W-1:0] in_r2R,
    input  logic [PKT_W-1:0] in_r1L,
    input  logic [PKT_W-1:0] in_r2L,
    output logic [PKT_W-1:0] rf_free,
    output logic [PKT_W-1:0] rf_r1R,
    output logic [PKT_W-1:0] rf_r2R,
    output logic [PKT_W-1:0] rf_r1L,
    output logic [PKT_W-1:0] rf_r2L,
    output logic [2:0]       grant_port,
    output logic [4:0]       ovf_flags,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned NP = 5;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [PKT_W-1:0] r_mem [NP][FIFO_DEPTH];
    logic [AW-1:0]    r_rd_ptr [NP];
    logic [AW-1:0]    r_wr_ptr [NP];
    logic [AW:0]      r_count [NP];
    logic [2:0]       r_rr_ptr;
    logic [PKT_W-1:0] r_rf [NP];
    logic [2:0]       r_grant;
    logic [NP-1:0]    r_ovf;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [PKT_W-1:0] w_in [NP];
    logic [PKT_W-1:0] w_head [NP];
    logic [NP-1:0]    w_cand;
    logic [NP-1:0]    w_full;
    logic [NP-1:0]    w_pop;
    logic [NP-1:0]    w_wr_en;
    logic [NP-1:0]    w_drop;
    logic             w_found;
    logic             w_issue;
    logic [2:0]       w_win;
    logic [2:0]       w_rr_next;
    logic [3:0]       w_idx;
    logic [2:0]       w_drop_num;
    logic [CNT_W:0]   w_drop_sum;
    logic [CNT_W-1:0] w_drop_next;

    assign w_in[0] = in_free;
    assign w_in[1] = in_r1R;
    assign w_in[2] = in_r2R;
    assign w_in[3] = in_r1L;
    assign w_in[4] = in_r2L;

    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            w_cand[i] = (r_count[i] != '0);
            w_full[i] = (r_count[i] == (AW+1)'(FIFO_DEPTH));
            w_head[i] = r_mem[i][r_rd_ptr[i]];
        end
    end

    always_comb begin
        w_found   = 1'b0;
        w_win     = 3'd0;
        w_rr_next = r_rr_ptr;
        w_idx     = '0;
`ifdef ARB_LOCAL_PRIO_EN
        // rr_ptr lives in 1..4 here; a reset value of 0 starts the search at 1
        for (int unsigned k = 0; k < 4; k++) begin
            w_idx = ((r_rr_ptr == 3'd0) ? 4'd1 : {1'b0, r_rr_ptr}) + 4'(k);
            if (w_idx > 4'd4) begin
                w_idx = w_idx - 4'd4;
            end
            if (!w_found && w_cand[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
        if (w_found) begin
            w_rr_next = (w_win == 3'd4) ? 3'd1 : w_win + 3'd1;
        end else if (w_cand[0]) begin
            w_found = 1'b1;
            w_win   = 3'd0;
        end
`else
        for (int unsigned k = 0; k < NP; k++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(k);
            if (w_idx >= 4'd5) begin
                w_idx = w_idx - 4'd5;
            end
            if (!w_found && w_cand[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
        if (w_found) begin
            w_rr_next = (w_win == 3'd4) ? 3'd0 : w_win + 3'd1;
        end
`endif
        w_issue = w_found && !stall;
        if (!w_issue) begin
            w_rr_next = r_rr_ptr;
        end
    end

    // A full FIFO still accepts a write when its head is popped on the same edge
    always_comb begin
        w_drop_num = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            w_pop[i]   = w_issue && (w_win == 3'(i));
            w_wr_en[i] = w_in[i][PKT_W-1] && (!w_full[i] || w_pop[i]);
            w_drop[i]  = w_in[i][PKT_W-1] && w_full[i] && !w_pop[i];
            w_drop_num = w_drop_num + {2'b00, w_drop[i]};
        end
        w_drop_sum  = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_num);
        w_drop_next = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NP; i++) begin
            if (w_wr_en[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NP; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
                r_rf[i]     <= '0;
            end
            r_rr_ptr   <= '0;
            r_grant    <= 3'd7;
            r_ovf      <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NP; i++) begin
                if (w_wr_en[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
                end
                case ({w_wr_en[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + (AW+1)'(1);
                    2'b01:   r_count[i] <= r_count[i] - (AW+1)'(1);
                    default: r_count[i] <= r_count[i];
                endcase
                r_rf[i] <= w_pop[i] ? w_head[i] : '0;
            end
            r_rr_ptr   <= w_rr_next;
            r_grant    <= w_issue ? w_win : 3'd7;
            r_ovf      <= r_ovf | w_drop;
            r_drop_cnt <= w_drop_next;
        end
    end

    assign rf_free    = r_rf[0];
    assign rf_r1R     = r_rf[1];
    assign rf_r2R     = r_rf[2];
    assign rf_r1L     = r_rf[3];
    assign rf_r2L     = r_rf[4];
    assign grant_port = r_grant;
    assign ovf_flags  = r_ovf;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_apo_input_arbiter_9_nodes.sv
// Directed bench for apo_input_arbiter_9_nodes; expected grants queued at drive time, popped on issue.
// Expectations for the priority scenarios follow `ARB_LOCAL_PRIO_EN when it is defined.
module tb_apo_input_arbiter_9_nodes;

    typedef struct packed {
        logic [2:0] port;
        logic [8:0] word;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       stall;
    logic [8:0] in_free, in_r1R, in_r2R, in_r1L, in_r2L;
    logic [8:0] rf_free, rf_r1R, rf_r2R, rf_r1L, rf_r2L;
    logic [2:0] grant_port;
    logic [4:0] ovf_flags;
    logic [7:0] drop_cnt;
    logic [44:0] rf_vec;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    apo_input_arbiter_9_nodes #(
        .PKT_W(9),
        .FIFO_DEPTH(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .in_free(in_free),
        .in_r1R(in_r1R),
        .in_r2R(in_r2R),
        .in_r1L(in_r1L),
        .in_r2L(in_r2L),
        .rf_free(rf_free),
        .rf_r1R(rf_r1R),
        .rf_r2R(rf_r2R),
        .rf_r1L(rf_r1L),
        .rf_r2L(rf_r2L),
        .grant_port(grant_port),
        .ovf_flags(ovf_flags),
        .drop_cnt(drop_cnt)
    );

    assign rf_vec = {rf_r2L, rf_r1L, rf_r2R, rf_r1R, rf_free};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    function automatic logic [44:0] place(input logic [2:0] p, input logic [8:0] w);
        logic [44:0] v;
        v = '0;
        v[int'(p)*9 +: 9] = w;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [8:0] f, input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] c, input logic [8:0] d, input logic s);
        in_free = f;
        in_r1R  = a;
        in_r2R  = b;
        in_r1L  = c;
        in_r2L  = d;
        stall   = s;
    endtask

    task automatic expect_grant(input logic [2:0] p, input logic [8:0] w);
        sb.push_back(exp_t'{port: p, word: w});
    endtask

    // One clock edge, then check whatever the DUT issued against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (grant_port === 3'd7) begin
            chk("idle_rf_zero", 64'(rf_vec), 64'(0));
        end else if (sb.size() == 0) begin
            chk("unexpected_grant", 64'(grant_port), 64'(3'd7));
        end else begin
            e = sb.pop_front();
            chk("grant_port", 64'(grant_port), 64'(e.port));
            chk("rf_word", 64'(rf_vec), 64'(place(e.port, e.word)));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_grant", 64'(grant_port), 64'(3'd7));
        chk("rst_rf", 64'(rf_vec), 64'(0));
        chk("rst_ovf", 64'(ovf_flags), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst = 1'b0;
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        #1;
        do_reset();

        // single local packet: one-edge latency, one-cycle output
        drive(9'h103, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        tick();
        expect_grant(3'd0, 9'h103);
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        tick();
        tick();
        chk("t1_drained", 64'(sb.size()), 64'(0));

        // invalid words are ignored
        drive(9'h0FF, 9'h055, 9'h0AA, 9'h001, 9'h0F0, 1'b0);
        tick();
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        tick();

        // all five ports at once
        do_reset();
        drive(9'h111, 9'h112, 9'h113, 9'h114, 9'h115, 1'b0);
`ifdef ARB_LOCAL_PRIO_EN
        expect_grant(3'd1, 9'h112);
        expect_grant(3'd2, 9'h113);
        expect_grant(3'd3, 9'h114);
        expect_grant(3'd4, 9'h115);
        expect_grant(3'd0, 9'h111);
`else
        expect_grant(3'd0, 9'h111);
        expect_grant(3'd1, 9'h112);
        expect_grant(3'd2, 9'h113);
        expect_grant(3'd3, 9'h114);
        expect_grant(3'd4, 9'h115);
`endif
        tick();
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        repeat (6) tick();
        chk("t2_drained", 64'(sb.size()), 64'(0));

        // overflow under stall on r1R
        do_reset();
        drive(9'h0, 9'h121, 9'h0, 9'h0, 9'h0, 1'b1);
        repeat (4) tick();
        chk("t3_ovf", 64'(ovf_flags), 64'(5'b00010));
        chk("t3_drop", 64'(drop_cnt), 64'(2));
        expect_grant(3'd1, 9'h121);
        expect_grant(3'd1, 9'h121);
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        repeat (3) tick();
        chk("t3_drained", 64'(sb.size()), 64'(0));

        // full FIFO written on the edge it is popped
        do_reset();
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h1A1, 1'b1);
        repeat (2) tick();
        expect_grant(3'd4, 9'h1A1);
        expect_grant(3'd4, 9'h1A1);
        expect_grant(3'd4, 9'h1A2);
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h1A2, 1'b0);
        tick();
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        repeat (3) tick();
        chk("t4_drop", 64'(drop_cnt), 64'(0));
        chk("t4_ovf", 64'(ovf_flags), 64'(0));
        chk("t4_drained", 64'(sb.size()), 64'(0));

        // simultaneous multi-port drops and counter saturation
        do_reset();
        drive(9'h150, 9'h151, 9'h152, 9'h153, 9'h154, 1'b1);
        repeat (3) tick();
        chk("sat_multi_drop", 64'(drop_cnt), 64'(5));
        repeat (57) tick();
        chk("sat_drop", 64'(drop_cnt), 64'(8'hFF));
        chk("sat_ovf", 64'(ovf_flags), 64'(5'b11111));
`ifdef ARB_LOCAL_PRIO_EN
        for (int r = 0; r < 2; r++) begin
            for (int p = 1; p < 5; p++) expect_grant(3'(p), 9'(9'h150 + p));
        end
        expect_grant(3'd0, 9'h150);
        expect_grant(3'd0, 9'h150);
`else
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 5; p++) expect_grant(3'(p), 9'(9'h150 + p));
        end
`endif
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        repeat (11) tick();
        chk("sat_drained", 64'(sb.size()), 64'(0));
        chk("sat_hold", 64'(drop_cnt), 64'(8'hFF));

        // asynchronous reset mid-burst
        do_reset();
        drive(9'h0, 9'h161, 9'h162, 9'h163, 9'h0, 1'b1);
        tick();
        expect_grant(3'd1, 9'h161);
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        tick();
        #2;
        do_reset();
        repeat (4) tick();

        // local versus transit traffic
        do_reset();
        drive(9'h1F0, 9'h0, 9'h0, 9'h1C0, 9'h0, 1'b0);
        tick();
`ifdef ARB_LOCAL_PRIO_EN
        expect_grant(3'd3, 9'h1C0);
        expect_grant(3'd3, 9'h1C1);
        expect_grant(3'd3, 9'h1C2);
        expect_grant(3'd0, 9'h1F0);
        expect_grant(3'd0, 9'h1F1);
`else
        expect_grant(3'd0, 9'h1F0);
        expect_grant(3'd3, 9'h1C0);
        expect_grant(3'd0, 9'h1F1);
        expect_grant(3'd3, 9'h1C1);
        expect_grant(3'd0, 9'h1F2);
        expect_grant(3'd3, 9'h1C2);
`endif
        drive(9'h1F1, 9'h0, 9'h0, 9'h1C1, 9'h0, 1'b0);
        tick();
        drive(9'h1F2, 9'h0, 9'h0, 9'h1C2, 9'h0, 1'b0);
        tick();
        drive(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
        repeat (5) tick();
        chk("t6_drained", 64'(sb.size()), 64'(0));
`ifdef ARB_LOCAL_PRIO_EN
        chk("t6_drop", 64'(drop_cnt), 64'(1));
        chk("t6_ovf", 64'(ovf_flags), 64'(5'b00001));
`else
        chk("t6_drop", 64'(drop_cnt), 64'(0));
        chk("t6_ovf", 64'(ovf_flags), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
